// File: rtl/multicycle_pkg.sv
// Shared constants, state encoding and ALU command decode for the multicycle ARM-subset controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        BRANCH,
        UNKNOWN
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       no_write;
        logic [1:0] flag_w;
    } alu_dec_t;

    // Unrecognised commands fall back to ADD with the register write and flag update killed.
    function automatic alu_dec_t decode_cmd(input logic [3:0] cmd, input logic s);
        alu_dec_t d;
        d.alu_control = ALU_ADD;
        d.no_write    = 1'b0;
        d.flag_w      = {s, 1'b0};
        case (cmd)
            CMD_ADD: d.flag_w[0] = s;
            CMD_SUB: begin
                d.alu_control = ALU_SUB;
                d.flag_w[0]   = s;
            end
            CMD_CMP: begin
                d.alu_control = ALU_SUB;
                d.no_write    = 1'b1;
                d.flag_w      = 2'b11;
            end
            CMD_AND: d.alu_control = ALU_AND;
            CMD_ORR: d.alu_control = ALU_ORR;
            CMD_EOR: d.alu_control = ALU_EOR;
            CMD_MOV: d.alu_control = ALU_MOV;
            default: begin
                d.no_write = 1'b1;
                d.flag_w   = 2'b00;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Combinational ARM condition-code evaluation against the architectural {N,Z,C,V} flags.
module cond_check
    import multicycle_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n;
    logic z;
    logic c;
    logic v;
    logic ge;

    assign {n, z, c, v} = flags;
    assign ge = (n == v);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ge;
            COND_LT: cond_ex = ~ge;
            COND_GT: cond_ex = ~z & ge;
            COND_LE: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM, instruction decode and flag register for the multicycle ARM-subset datapath.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  Flags
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_rn;

    state_t   state;
    state_t   state_next;
    alu_dec_t dec;
    logic     cond_ex;
    logic     cond_ex_q;
    logic     in_execute;

    logic pc_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic ir_write_raw;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

    assign dec        = decode_cmd(funct[4:1], funct[0]);
    assign in_execute = (state == EXECUTER) || (state == EXECUTEI);

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (Flags),
        .cond_ex (cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // The condition verdict is frozen at DECODE so the flag update in EXECUTE cannot affect its own instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_q <= 1'b0;
        end else if (state == DECODE) begin
            cond_ex_q <= cond_ex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else if (in_execute && cond_ex_q) begin
            if (dec.flag_w[1]) begin
                Flags[3:2] <= ALUFlags[3:2];
            end
            if (dec.flag_w[0]) begin
                Flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_next    = FETCH;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        AdrSrc        = 1'b0;
        ALUSrcA       = SRCA_RD1;
        ALUSrcB       = SRCB_REG;
        ResultSrc     = RES_ALUOUT;
        ALUControl    = ALU_ADD;
        case (state)
            FETCH: begin
                state_next   = DECODE;
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    OP_DP:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                state_next = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = cond_ex_q;
            end
            MEMWR: begin
                AdrSrc        = 1'b1;
                mem_write_raw = cond_ex_q;
            end
            EXECUTER: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = dec.alu_control;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec.alu_control;
                state_next = ALUWB;
            end
            ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = cond_ex_q & ~dec.no_write;
                pc_write_raw  = cond_ex_q & ~dec.no_write & (rd == 4'hF);
            end
            BRANCH: begin
                ALUSrcA      = SRCA_ALUOUT;
                ALUSrcB      = SRCB_IMM;
                ResultSrc    = RES_ALURESULT;
                pc_write_raw = cond_ex_q;
            end
            UNKNOWN: state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, whose enables would otherwise be live; mask them until release.
    assign PCWrite  = pc_write_raw & reset;
    assign MemWrite = mem_write_raw & reset;
    assign RegWrite = reg_write_raw & reset;
    assign IRWrite  = ir_write_raw & reset;

    assign ImmSrc = op;
    assign RegSrc = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level reference model queues per-cycle expectations; a monitor compares them.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  Flags;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_control;
        logic [3:0] flags;
    } obs_t;

    obs_t       exp_q[$];
    int         checks = 0;
    int         fails = 0;
    int         cycle_no = 0;
    logic [3:0] model_flags;

    function automatic string fmt(input obs_t o);
        return $sformatf("pcw=%0b memw=%0b regw=%0b irw=%0b adr=%0b srca=%0d srcb=%0d res=%0d imm=%0d regsrc=%0d alu=%0d flags=%b",
                         o.pc_write, o.mem_write, o.reg_write, o.ir_write, o.adr_src, o.alu_src_a,
                         o.alu_src_b, o.result_src, o.imm_src, o.reg_src, o.alu_control, o.flags);
    endfunction

    function automatic logic [19:0] mk_ins(input logic [3:0] cond, input logic [1:0] op,
                                           input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h2, rd};
    endfunction

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t mk_base(input logic [19:0] ins, input logic [3:0] f);
        obs_t o;
        o         = '0;
        o.imm_src = ins[15:14];
        o.reg_src = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        o.flags   = f;
        return o;
    endfunction

    // PC+4 address path with every write enable low; shared by DECODE and the held-in-reset cycles.
    function automatic obs_t mk_pc_path(input logic [19:0] ins, input logic [3:0] f);
        obs_t o;
        o            = mk_base(ins, f);
        o.alu_src_a  = 2'b01;
        o.alu_src_b  = 2'b10;
        o.result_src = 2'b10;
        return o;
    endfunction

    task automatic applyStimulus(input logic rst_val, input logic [19:0] ins,
                                 input logic [3:0] af, input obs_t e);
        @(posedge clk);
        #1;
        reset    = rst_val;
        Instr    = ins;
        ALUFlags = af;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input obs_t e);
        obs_t a;
        a.pc_write    = PCWrite;
        a.mem_write   = MemWrite;
        a.reg_write   = RegWrite;
        a.ir_write    = IRWrite;
        a.adr_src     = AdrSrc;
        a.alu_src_a   = ALUSrcA;
        a.alu_src_b   = ALUSrcB;
        a.result_src  = ResultSrc;
        a.imm_src     = ImmSrc;
        a.reg_src     = RegSrc;
        a.alu_control = ALUControl;
        a.flags       = Flags;
        checks++;
        if (a !== e) begin
            fails++;
            $display("[TB] FAIL cycle %0d outputs: actual %s | required %s", cycle_no, fmt(a), fmt(e));
        end
    endtask

    always @(negedge clk) begin
        cycle_no++;
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    // Reference model: expands one instruction into its per-cycle expected outputs, then drives it.
    task automatic run_instr(input logic [19:0] ins, input int abort_at, input int af_force);
        obs_t       seq[$];
        obs_t       o;
        logic [3:0] cond, rd, cmd, af_exe, new_flags;
        logic [1:0] op;
        logic [5:0] funct;
        logic [2:0] code;
        bit         pass, valid, arith, is_cmp, s;

        cond      = ins[19:16];
        op        = ins[15:14];
        funct     = ins[13:8];
        rd        = ins[3:0];
        cmd       = funct[4:1];
        s         = funct[0];
        pass      = cond_holds(cond, model_flags);
        af_exe    = (af_force >= 0) ? af_force[3:0] : 4'($urandom);
        new_flags = model_flags;

        o          = mk_pc_path(ins, model_flags);
        o.pc_write = 1'b1;
        o.ir_write = 1'b1;
        seq.push_back(o);
        seq.push_back(mk_pc_path(ins, model_flags));

        case (op)
            2'b00: begin
                valid = 1'b1;
                case (cmd)
                    4'b0100: code = 3'd0;
                    4'b0010: code = 3'd1;
                    4'b1010: code = 3'd1;
                    4'b0000: code = 3'd2;
                    4'b1100: code = 3'd3;
                    4'b0001: code = 3'd4;
                    4'b1101: code = 3'd5;
                    default: begin
                        code  = 3'd0;
                        valid = 1'b0;
                    end
                endcase
                is_cmp = (cmd == 4'b1010);
                arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
                if (pass && valid) begin
                    if (s || is_cmp) new_flags[3:2] = af_exe[3:2];
                    if ((s && arith) || is_cmp) new_flags[1:0] = af_exe[1:0];
                end
                o             = mk_base(ins, model_flags);
                o.alu_src_b   = funct[5] ? 2'b01 : 2'b00;
                o.alu_control = code;
                seq.push_back(o);
                o           = mk_base(ins, new_flags);
                o.reg_write = pass && valid && !is_cmp;
                o.pc_write  = pass && valid && !is_cmp && (rd == 4'hF);
                seq.push_back(o);
            end
            2'b01: begin
                o           = mk_base(ins, model_flags);
                o.alu_src_b = 2'b01;
                seq.push_back(o);
                if (funct[0]) begin
                    o         = mk_base(ins, model_flags);
                    o.adr_src = 1'b1;
                    seq.push_back(o);
                    o            = mk_base(ins, model_flags);
                    o.result_src = 2'b01;
                    o.reg_write  = pass;
                    seq.push_back(o);
                end else begin
                    o           = mk_base(ins, model_flags);
                    o.adr_src   = 1'b1;
                    o.mem_write = pass;
                    seq.push_back(o);
                end
            end
            2'b10: begin
                o            = mk_base(ins, model_flags);
                o.alu_src_a  = 2'b10;
                o.alu_src_b  = 2'b01;
                o.result_src = 2'b10;
                o.pc_write   = pass;
                seq.push_back(o);
            end
            default: seq.push_back(mk_base(ins, model_flags));
        endcase

        foreach (seq[i]) begin
            if (i == abort_at) begin
                applyStimulus(1'b0, ins, 4'($urandom), mk_pc_path(ins, 4'b0000));
                applyStimulus(1'b0, ins, 4'($urandom), mk_pc_path(ins, 4'b0000));
                model_flags = 4'b0000;
                return;
            end
            applyStimulus(1'b1, ins, (op == 2'b00 && i == 2) ? af_exe : 4'($urandom), seq[i]);
        end
        model_flags = new_flags;
    endtask

    initial begin
        logic [31:0] r;
        int          abort_at;

        reset       = 1'b0;
        Instr       = 20'h0;
        ALUFlags    = 4'h0;
        model_flags = 4'b0000;
        applyStimulus(1'b0, 20'h0, 4'h0, mk_pc_path(20'h0, 4'b0000));
        applyStimulus(1'b0, 20'h0, 4'h0, mk_pc_path(20'h0, 4'b0000));

        run_instr(mk_ins(4'hE, 2'b00, 6'b001001, 4'h1), -1, 4'b0110);
        run_instr(mk_ins(4'hE, 2'b00, 6'b010101, 4'h0), -1, 4'b0100);
        run_instr(mk_ins(4'h0, 2'b10, 6'b000000, 4'h0), -1, -1);
        run_instr(mk_ins(4'hE, 2'b00, 6'b010101, 4'h0), -1, 4'b0000);
        run_instr(mk_ins(4'h0, 2'b10, 6'b000000, 4'h0), -1, -1);
        run_instr(mk_ins(4'hE, 2'b01, 6'b011001, 4'h3), -1, -1);
        run_instr(mk_ins(4'hE, 2'b01, 6'b011000, 4'h3), -1, -1);
        run_instr(mk_ins(4'hE, 2'b00, 6'b010101, 4'h0), -1, 4'b1011);
        run_instr(mk_ins(4'hE, 2'b00, 6'b000001, 4'h4), -1, 4'b0100);
        run_instr(mk_ins(4'hE, 2'b11, 6'b001001, 4'h5), -1, -1);
        run_instr(mk_ins(4'hF, 2'b00, 6'b001001, 4'h5), -1, 4'b1111);
        run_instr(mk_ins(4'hE, 2'b00, 6'b001001, 4'hF), -1, 4'b1010);
        run_instr(mk_ins(4'hE, 2'b00, 6'b001001, 4'h1), 2, 4'b1111);
        run_instr(mk_ins(4'hE, 2'b00, 6'b101001, 4'h6), -1, 4'b1001);

        for (int k = 0; k < 250; k++) begin
            r        = $urandom;
            abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(r[19:0], abort_at, -1);
        end
        run_instr(mk_ins(4'hE, 2'b00, 6'b011011, 4'h7), -1, -1);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard drain: actual %0d pending entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset datapath; direct upstream driver and downstream consumer of the ALU.
- Decodes Instr[31:12] and sequences each instruction through a main FSM.
- Generates ALUControl and all datapath enables/selects.
- Registers the ALU's ALUFlags{N,Z,C,V} and evaluates condition codes to gate architectural writes.

Parameters:
- none (instruction format and encodings fixed by ISA; constants live in package)

Ports:
- clk           in   1   system clock, rising edge
- reset         in   1   asynchronous, active-low reset
- Instr         in   20  Instr[31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags      in   4   {N,Z,C,V} from ALU, combinational, same cycle
- PCWrite       out  1   PC register enable
- MemWrite      out  1   data memory write
- RegWrite      out  1   register file write
- IRWrite       out  1   instruction register load
- AdrSrc        out  1   0=PC, 1=ALUOut as memory address
- ALUSrcA       out  2   00=RD1(A), 01=PC, 10=ALUOut
- ALUSrcB       out  2   00=RD2 / ExtImm mux as decoded, 01=ExtImm, 10=const 4
- ResultSrc     out  2   00=ALUOut, 01=Data, 10=ALUResult
- ImmSrc        out  2   = op
- RegSrc        out  2   [0]=(op==10), [1]=(op==01)
- ALUControl    out  3   000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV
- Flags         out  4   architectural flag register, for debug/trace

Behaviour:
- Reset (async, reset==0): state=FETCH, Flags=0000, cond_ex_q=0; all write enables low while reset asserted.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op=00 & funct[5]=0 -> EXECUTER; op=00 & funct[5]=1 -> EXECUTEI; op=01 -> MEMADR; op=10 -> BRANCH; op=11 -> UNKNOWN.
  - MEMADR: funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH; UNKNOWN->FETCH.
- Per-state outputs (unlisted = 0/00):
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1 (unconditional), ALU ADD.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU ADD.
  - MEMADR: ALUSrcB=01, ALU ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=cond_ex_q.
  - MEMWR: AdrSrc=1, MemWrite=cond_ex_q.
  - EXECUTER: ALUSrcB=00, ALU per funct.
  - EXECUTEI: ALUSrcB=01, ALU per funct.
  - ALUWB: ResultSrc=00, RegWrite=cond_ex_q & ~NoWrite; PCWrite=cond_ex_q & ~NoWrite & (Rd==15).
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALU ADD, PCWrite=cond_ex_q.
  - UNKNOWN: no writes.
- ALU decode (EXECUTE states only; all other states drive ADD):
  - cmd=funct[4:1]: 0100 ADD, 0010 SUB, 1010 CMP (SUB, NoWrite=1), 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV.
  - Any other cmd -> ADD, RegWrite suppressed.
- FlagW:
  - FlagW[1] (N,Z) = S (funct[0]) for any valid cmd; CMP forces FlagW=11.
  - FlagW[0] (C,V) = S & cmd in {ADD,SUB,CMP}; logical ops leave C,V unchanged.
- Condition check (combinational on Flags and cond):
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
  - Result registered into cond_ex_q on the clock edge leaving DECODE; held until next DECODE.
- Flag update: on edge leaving EXECUTER/EXECUTEI, if cond_ex_q, load Flags[3:2]<=ALUFlags[3:2] when FlagW[1], Flags[1:0]<=ALUFlags[1:0] when FlagW[0]. No flag update in any other state.
- Latencies: data-processing 4 cycles, LDR 5, STR 4, B 3.
- Reset mid-instruction aborts it: no partial write survives; restart at FETCH.

Decomposition:
- Package multicycle_pkg: state enum; ALUControl codes; cmd encodings; cond-code constants; ALUSrc/ResultSrc select constants.
- One sub-module, cond_check: cond[3:0] + Flags -> CondEx (pure combinational).
- FSM, decoders and flag register stay in the top.

Test Plan:
- Reset asserted during EXECUTER -> state=FETCH immediately; Flags=0000; RegWrite=MemWrite=PCWrite=0 until release.
- ADDS (cond=1110, op=00, funct=001001), ALUFlags=0110 in EXECUTER -> ALUControl=000; Flags=0110 after that edge; RegWrite=1 only in ALUWB; 4 cycles total.
- CMP (funct=010101) with ALUFlags=0100, then BEQ (cond=0000, op=10) -> BRANCH PCWrite=1. Repeat with ALUFlags=0000 -> PCWrite=0. Both: RegWrite=0 throughout CMP.
- LDR (op=01, funct[0]=1) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; RegWrite only in MEMWB. STR -> MemWrite only in MEMWR.
- Flags=1011, ANDS with ALUFlags=0100 -> Flags=0111 (N,Z updated; C,V retained).
- op=11, or cond=1111 on ADD -> no RegWrite, MemWrite or PCWrite beyond FETCH; Flags unchanged.
